// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan engine: FSM states, width helpers
// and the bit layout of a packed framebuffer word.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_DISP,
    PRE_BLANK,
    LATCH,
    POST_BLANK
  } state_e;

  localparam int unsigned FIELDS_PER_CHAIN = 6;
  localparam int unsigned BRIGHT_W         = 8;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Widest load is 255 << (BITS-1+BASE_SHIFT), so this never overflows.
  function automatic int unsigned disp_cnt_w(input int unsigned bits, input int unsigned base_shift);
    return BRIGHT_W + bits - 1 + base_shift;
  endfunction

  // Field f (0=r1 .. 5=b2) of chain c; r1 is the most significant field of a chain.
  function automatic int unsigned field_lsb(input int unsigned c, input int unsigned f,
                                            input int unsigned bits);
    return (c * FIELDS_PER_CHAIN + (FIELDS_PER_CHAIN - 1 - f)) * bits;
  endfunction

endpackage

// File: rtl/hub75_row_select.sv
// Row shift-register driver: one row_clk pulse per row advance, with row_data
// high only on the pulse that clocks in row 0.
module hub75_row_select (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic advance_i,
  input  logic row_is_zero_i,
  output logic row_clk_o,
  output logic row_data_o
);

  logic row_clk_q, row_clk_d;
  logic row_data_q, row_data_d;

  assign row_clk_d  = advance_i;
  assign row_data_d = advance_i & row_is_zero_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_clk_q  <= 1'b0;
      row_data_q <= 1'b0;
    end else begin
      row_clk_q  <= row_clk_d;
      row_data_q <= row_data_d;
    end
  end

  assign row_clk_o  = row_clk_q;
  assign row_data_o = row_data_q;

endmodule

// File: rtl/hub75_scan_engine.sv
// HUB75 scan engine: column shifter, BCM display timer and row sequencing.
// Define HUB75_GHOST_BLANK_EN for a 4x blank window with zeroed rgb on row change.
module hub75_scan_engine
  import hub75_pkg::*;
#(
  parameter int unsigned CHAINS     = 2,
  parameter int unsigned COLS       = 64,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned BITS       = 8,
  parameter int unsigned BASE_SHIFT = 2,
  parameter int unsigned BLANK_CYC  = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   enable_i,
  input  logic [7:0]                             brightness_i,
  output logic [addr_w(ROWS)+addr_w(COLS)-1:0]   fb_raddr_o,
  output logic                                   fb_re_o,
  input  logic [CHAINS*FIELDS_PER_CHAIN*BITS-1:0] fb_rdata_i,
  output logic [CHAINS*FIELDS_PER_CHAIN-1:0]     rgb_o,
  output logic                                   clk_out_o,
  output logic                                   lat_o,
  output logic                                   blank_o,
  output logic                                   row_clk_o,
  output logic                                   row_data_o,
  output logic                                   frame_done_o
);

  localparam int unsigned ROW_W = addr_w(ROWS);
  localparam int unsigned COL_W = addr_w(COLS);
  localparam int unsigned BIT_W = addr_w(BITS);
  localparam int unsigned CNT_W = disp_cnt_w(BITS, BASE_SHIFT);
  localparam int unsigned NRGB  = CHAINS * FIELDS_PER_CHAIN;
  localparam int unsigned PH_W  = addr_w(2 * COLS + 4 * BLANK_CYC + 2);
`ifdef HUB75_GHOST_BLANK_EN
  localparam int unsigned ROW_BLANK_CYC = 4 * BLANK_CYC;
`else
  localparam int unsigned ROW_BLANK_CYC = BLANK_CYC;
`endif
  localparam int unsigned ROW_STROBE_PH = (ROW_BLANK_CYC / 2 > 0) ? ROW_BLANK_CYC / 2 - 1 : 0;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [BIT_W-1:0] lat_bit_q, lat_bit_d;
  logic [7:0]       bright_q, bright_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  logic             shifted_q, shifted_d;
  logic             clk_out_q, clk_out_d;
  logic             blank_q, blank_d;
  logic [NRGB-1:0]  rgb_q, rgb_d;
  logic [NRGB-1:0]  plane_bits;
  logic             new_row, row_last, bit_last, pre_last, post_last, shift_last, disp_zero;
  logic             row_adv;

  // row_q/bit_q name the plane being shifted, which is also the next one latched.
  assign new_row    = (bit_q == '0);
  assign row_last   = (row_q == ROW_W'(ROWS - 1));
  assign bit_last   = (bit_q == BIT_W'(BITS - 1));
  assign pre_last   = new_row ? (ph_q == PH_W'(ROW_BLANK_CYC - 1)) : (ph_q == PH_W'(BLANK_CYC - 1));
  assign post_last  = (ph_q == PH_W'(BLANK_CYC - 1));
  assign shift_last = (ph_q == PH_W'(2 * COLS));
  assign disp_zero  = (disp_q == '0);

  for (genvar gc = 0; gc < CHAINS; gc++) begin : g_chain
    for (genvar gf = 0; gf < FIELDS_PER_CHAIN; gf++) begin : g_field
      logic [BITS-1:0] field;
      assign field = fb_rdata_i[field_lsb(gc, gf, BITS) +: BITS];
      assign plane_bits[gc * FIELDS_PER_CHAIN + FIELDS_PER_CHAIN - 1 - gf] = field[bit_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (enable_i)   state_d = SHIFT;
      SHIFT:      if (shift_last) state_d = WAIT_DISP;
      WAIT_DISP:  if (disp_zero)  state_d = shifted_q ? PRE_BLANK : IDLE;
      PRE_BLANK:  if (pre_last)   state_d = LATCH;
      LATCH:                      state_d = POST_BLANK;
      POST_BLANK: if (post_last)  state_d = enable_i ? SHIFT : WAIT_DISP;
      default:                    state_d = IDLE;
    endcase
  end

  // Reads run one column ahead of the shift clock: even phases fetch, odd phases present.
  always_comb begin
    fb_re_o      = 1'b0;
    fb_raddr_o   = '0;
    lat_o        = 1'b0;
    frame_done_o = 1'b0;
    row_adv      = 1'b0;
    unique case (state_q)
      SHIFT: begin
        if (!ph_q[0] && !shift_last) begin
          fb_re_o    = 1'b1;
          fb_raddr_o = {row_q, ph_q[COL_W:1]};
        end
      end
      PRE_BLANK: row_adv = new_row && (ph_q == PH_W'(ROW_STROBE_PH));
      LATCH: begin
        lat_o        = 1'b1;
        frame_done_o = row_last && bit_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    ph_d      = (state_d != state_q) ? '0 : ph_q + PH_W'(1);
    row_d     = row_q;
    bit_d     = bit_q;
    lat_bit_d = lat_bit_q;
    bright_d  = bright_q;
    shifted_d = shifted_q;
    rgb_d     = rgb_q;
    clk_out_d = (state_q == SHIFT) && !ph_q[0] && (ph_q != '0);
    disp_d    = disp_zero ? '0 : disp_q - CNT_W'(1);
    if (state_q == SHIFT && ph_q[0]) rgb_d = plane_bits;
`ifdef HUB75_GHOST_BLANK_EN
    if (state_q == PRE_BLANK && new_row) rgb_d = '0;
`endif
    if (state_q == SHIFT && shift_last) shifted_d = 1'b1;
    if (state_q == LATCH) begin
      shifted_d = 1'b0;
      lat_bit_d = bit_q;
      bright_d  = brightness_i;
      if (bit_last) begin
        bit_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        bit_d = bit_q + BIT_W'(1);
      end
    end
    if (state_q == POST_BLANK && post_last)
      disp_d = CNT_W'(bright_q) << (32'(lat_bit_q) + BASE_SHIFT);
    blank_d = (disp_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph_q      <= '0;
      row_q     <= '0;
      bit_q     <= '0;
      lat_bit_q <= '0;
      bright_q  <= '0;
      disp_q    <= '0;
      shifted_q <= 1'b0;
      clk_out_q <= 1'b0;
      blank_q   <= 1'b1;
      rgb_q     <= '0;
    end else begin
      ph_q      <= ph_d;
      row_q     <= row_d;
      bit_q     <= bit_d;
      lat_bit_q <= lat_bit_d;
      bright_q  <= bright_d;
      disp_q    <= disp_d;
      shifted_q <= shifted_d;
      clk_out_q <= clk_out_d;
      blank_q   <= blank_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rgb_o     = rgb_q;
  assign clk_out_o = clk_out_q;
  assign blank_o   = blank_q;

  hub75_row_select u_row_select (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .advance_i     (row_adv),
    .row_is_zero_i (row_q == '0),
    .row_clk_o     (row_clk_o),
    .row_data_o    (row_data_o)
  );

endmodule
